wf_rgb_frame_writer: RTL

- Upstream stage of the RGB dot-matrix scanner. It owns the write port of the 64x16 pixel RAM that the scanner reads.
- Accepts single-pixel writes through a valid/ready handshake and buffers them in a small FIFO.
- Accepts whole-frame fill requests.
- Commits to RAM only inside the scan-idle window, which runs from the scanner's scan_done to the next scan_en. The scanner therefore never reads a half-updated row.

---
 rtl/wf_rgb_pkg.sv | 41 ++++
 rtl/wf_sync_fifo.sv | 70 +++++++
 rtl/wf_rgb_frame_writer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/wf_rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wf_rgb_pkg
// Description : Shared pixel constants, write-port state encoding and helpers
//               for the RGB dot-matrix frame writer and scanner.
// Revision    : 1.0 - initial release
// ============================================================================
package wf_rgb_pkg;

    localparam int PIXEL_W    = 16;
    localparam int PIX_ADDR_W = 6;
    localparam int NUM_PIX    = 64;

    // Bit offsets of the 5-bit colour fields inside a pixel word
    localparam int RED = 10;
    localparam int GRN = 5;
    localparam int BLU = 0;

    // Width of one queued pixel write: {addr, pixel}
    localparam int FIFO_W = PIX_ADDR_W + PIXEL_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2
    } wr_state_t;

    // Builds a pixel word from its colour components; the top bit is unused
    function automatic logic [PIXEL_W-1:0] rgb_pack(input logic [4:0] r,
                                                    input logic [4:0] g,
                                                    input logic [4:0] b);
        logic [PIXEL_W-1:0] px;
        px = '0;
        px[RED +: 5] = r;
        px[GRN +: 5] = g;
        px[BLU +: 5] = b;
        return px;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wf_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wf_sync_fifo
// Description : Single-clock FIFO with occupancy count. Pushes while full and
//               pops while empty are ignored. Read data is the head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module wf_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 22,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] c_depth_lvl = LVL_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [LVL_W-1:0]   r_level;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_level == c_depth_lvl);
    assign empty     = (r_level == '0);
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;
    assign dout      = r_mem[r_rd_ptr];
    assign level     = r_level;

    // Storage: data needs no reset, validity is tracked by the level count
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wf_rgb_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : wf_rgb_frame_writer
// Description : Owns the write port of the 64x16 pixel RAM. Queues single
//               pixel writes and whole-frame fills, and commits them only
//               while the scanner is idle (scan_done .. next scan_en).
// Revision    : 1.0 - initial release
// ============================================================================
module wf_rgb_frame_writer
    import wf_rgb_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LVL_W      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scan_en,
    input  logic                  scan_done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [PIX_ADDR_W-1:0] in_addr,
    input  logic [PIXEL_W-1:0]    in_pixel,
    input  logic                  fill_req,
    input  logic [PIXEL_W-1:0]    fill_pixel,
    output logic                  fill_busy,
    output logic [LVL_W-1:0]      fifo_level,
    output logic                  ram_wr_en,
    output logic [PIX_ADDR_W-1:0] ram_wr_addr,
    output logic [PIXEL_W-1:0]    ram_wr_pixels
);

    localparam logic [PIX_ADDR_W-1:0] c_last_addr = PIX_ADDR_W'(NUM_PIX - 1);
    localparam logic [LVL_W-1:0]      c_lvl_one   = LVL_W'(1);

    wr_state_t             r_state;
    logic                  r_window;
    logic [PIX_ADDR_W-1:0] r_fill_addr;
    logic [PIXEL_W-1:0]    r_fill_pixel;
    logic                  r_fill_busy;
    logic                  r_wr_en;
    logic [PIX_ADDR_W-1:0] r_wr_addr;
    logic [PIXEL_W-1:0]    r_wr_pixels;

    logic                  w_go;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [LVL_W-1:0]      w_level;
    logic [FIFO_W-1:0]     w_fifo_dout;

    // A scan_en arriving this cycle closes the window before any write is decided
    assign w_go   = r_window & ~scan_en;
    assign w_push = in_valid & ~w_full;
    assign w_pop  = (r_state == DRAIN) & w_go & ~w_empty;

    wf_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset),
        .push  (w_push),
        .din   ({in_addr, in_pixel}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .level (w_level),
        .full  (w_full),
        .empty (w_empty)
    );

    // Scan-idle window: opened by scan_done, closed by scan_en (scan_en wins)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_window <= 1'b0;
        end else if (scan_en) begin
            r_window <= 1'b0;
        end else if (scan_done) begin
            r_window <= 1'b1;
        end
    end

    // Write sequencer: fills take priority over queued pixels; one write per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_fill_addr  <= '0;
            r_fill_pixel <= '0;
            r_fill_busy  <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_pixels  <= '0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_go && r_fill_busy) begin
                        r_state <= FILL;
                    end else if (w_go && !w_empty) begin
                        r_state <= DRAIN;
                    end
                end
                FILL: begin
                    if (w_go) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= r_fill_addr;
                        r_wr_pixels <= r_fill_pixel;
                        if (r_fill_addr == c_last_addr) begin
                            r_fill_busy <= 1'b0;
                            r_state     <= IDLE;
                        end else begin
                            r_fill_addr <= r_fill_addr + PIX_ADDR_W'(1);
                        end
                    end else begin
                        // Window closed: keep fill_addr so the next window resumes
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (w_pop) begin
                        r_wr_en     <= 1'b1;
                        r_wr_addr   <= w_fifo_dout[PIXEL_W +: PIX_ADDR_W];
                        r_wr_pixels <= w_fifo_dout[PIXEL_W-1:0];
                        // Leave after the last entry, or hand over to a pending fill
                        if (r_fill_busy || (w_level == c_lvl_one && !w_push)) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A new fill request restarts the fill from address 0
            if (fill_req) begin
                r_fill_pixel <= fill_pixel;
                r_fill_busy  <= 1'b1;
                r_fill_addr  <= '0;
            end
        end
    end

    assign in_ready      = ~w_full;
    assign fifo_level    = w_level;
    assign fill_busy     = r_fill_busy;
    assign ram_wr_en     = r_wr_en;
    assign ram_wr_addr   = r_wr_addr;
    assign ram_wr_pixels = r_wr_pixels;

endmodule
`default_nettype wire
